// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider: 50% clk_out plus a one-cycle tick per toggle.
// New divisors are staged in a pending register and applied only at a period boundary.
module prog_clk_div #(
    parameter int CTR_WIDTH   = 19,
    parameter int DEFAULT_DIV = 400_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [CTR_WIDTH-1:0] div_in,
    input  logic                 div_valid,
    output logic                 div_ready,
    output logic                 clk_out,
    output logic                 tick,
    output logic [CTR_WIDTH-1:0] div_cur
);

    // Handshake: a divisor transfers on any edge where div_valid && div_ready;
    // div_valid while div_ready is low is dropped, never queued or stalled.

    localparam logic [CTR_WIDTH-1:0] ONE     = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] DEF_DIV = CTR_WIDTH'(DEFAULT_DIV);

    logic [CTR_WIDTH-1:0] ctr;
    logic [CTR_WIDTH-1:0] pend;
    logic [CTR_WIDTH-1:0] div_last;
    logic [CTR_WIDTH-1:0] div_clamped;
    logic                 accept;
    logic                 terminal;
    logic                 apply;

    // div_cur is never zero (clamped on capture), so div_cur-1 cannot underflow.
    assign div_last    = div_cur - ONE;
    assign div_clamped = (div_in == '0) ? ONE : div_in;
    assign terminal    = en && (ctr == div_last);
    assign accept      = div_valid && div_ready;
    // A pending divisor exists exactly when div_ready is low.
    assign apply       = !div_ready && (clr || !en || terminal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr       <= '0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            div_cur   <= DEF_DIV;
            pend      <= '0;
            div_ready <= 1'b1;
        end else begin
            if (clr) begin
                ctr     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (!en) begin
                tick <= 1'b0;
                if (apply) begin
                    ctr <= '0;
                end
            end else if (terminal) begin
                ctr     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
            end else begin
                ctr  <= ctr + ONE;
                tick <= 1'b0;
            end

            // apply needs div_ready low and accept needs it high, so they never coincide.
            if (apply) begin
                div_cur   <= pend;
                div_ready <= 1'b1;
            end else if (accept) begin
                pend      <= div_clamped;
                div_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div (CTR_WIDTH=8, DEFAULT_DIV=4) with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_prog_clk_div;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic [W-1:0] div_in;
    logic         div_valid;
    logic         div_ready;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] div_cur;

    int n_checks;
    int n_errors;

    prog_clk_div #(.CTR_WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .div_cur   (div_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic exp_clk, input logic exp_tick);
        check({tag, ".clk_out"}, 32'(clk_out), 32'(exp_clk));
        check({tag, ".tick"}, 32'(tick), 32'(exp_tick));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        div_in    = '0;
        div_valid = 1'b0;

        // Reset values
        #23;
        check_out("reset", 1'b0, 1'b0);
        check("reset.div_cur", 32'(div_cur), 4);
        check("reset.div_ready", 32'(div_ready), 1);

        // Default divisor 4: first rise on 4th edge, period 8
        rst_n = 1'b1;
        en    = 1'b1;
        step(3);
        check_out("t1.pre_rise", 1'b0, 1'b0);
        step(1);
        check_out("t1.rise", 1'b1, 1'b1);
        step(3);
        check_out("t1.high", 1'b1, 1'b0);
        step(1);
        check_out("t1.fall", 1'b0, 1'b1);

        // Load divisor 2 at ctr=1; busy second request ignored
        step(1);
        div_valid = 1'b1;
        div_in    = 8'd2;
        step(1);
        check("t3.ready_drop", 32'(div_ready), 0);
        check("t3.div_old", 32'(div_cur), 4);
        div_in = 8'd7;
        step(1);
        check("t3.busy_ready", 32'(div_ready), 0);
        check_out("t3.mid", 1'b0, 1'b0);
        div_valid = 1'b0;
        step(1);
        check_out("t3.apply", 1'b1, 1'b1);
        check("t3.div_new", 32'(div_cur), 2);
        check("t3.ready_back", 32'(div_ready), 1);
        step(1);
        check_out("t3.half1", 1'b1, 1'b0);
        step(1);
        check_out("t3.half2", 1'b0, 1'b1);
        check("t3.ignored", 32'(div_cur), 2);

        // div_in=0 clamps to 1: toggle every cycle, tick held high
        div_valid = 1'b1;
        div_in    = 8'd0;
        step(1);
        div_valid = 1'b0;
        check_out("t4.accept", 1'b0, 1'b0);
        step(1);
        check_out("t4.apply", 1'b1, 1'b1);
        check("t4.div_clamp", 32'(div_cur), 1);
        step(1);
        check_out("t4.cyc1", 1'b0, 1'b1);
        step(1);
        check_out("t4.cyc2", 1'b1, 1'b1);

        // Accept coincides with terminal: old divisor used there
        div_valid = 1'b1;
        div_in    = 8'd4;
        step(1);
        div_valid = 1'b0;
        check_out("t4b.same_edge", 1'b0, 1'b1);
        check("t4b.div_old", 32'(div_cur), 1);
        check("t4b.ready", 32'(div_ready), 0);
        step(1);
        check_out("t4b.apply", 1'b1, 1'b1);
        check("t4b.div_new", 32'(div_cur), 4);

        // Enable low for 10 cycles at ctr=2
        step(2);
        en = 1'b0;
        step(5);
        check_out("t5.frozen_mid", 1'b1, 1'b0);
        step(5);
        check_out("t5.frozen_end", 1'b1, 1'b0);
        en = 1'b1;
        step(1);
        check_out("t5.resume1", 1'b1, 1'b0);
        step(1);
        check_out("t5.resume2", 1'b0, 1'b1);

        // clr coincident with terminal count while clk_out=1
        step(4);
        check_out("t6.rise", 1'b1, 1'b1);
        step(3);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_out("t6.clr", 1'b0, 1'b0);
        step(3);
        check_out("t6.post_clr3", 1'b0, 1'b0);
        step(1);
        check_out("t6.post_clr4", 1'b1, 1'b1);

        // Pending divisor applied by clr
        div_valid = 1'b1;
        div_in    = 8'd3;
        step(1);
        div_valid = 1'b0;
        check("t6b.pending", 32'(div_ready), 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("t6b.div_clr", 32'(div_cur), 3);
        check("t6b.ready_clr", 32'(div_ready), 1);
        check_out("t6b.clr", 1'b0, 1'b0);
        step(2);
        check_out("t6b.pre", 1'b0, 1'b0);
        step(1);
        check_out("t6b.rise", 1'b1, 1'b1);

        // Asynchronous reset mid-cycle
        rst_n = 1'b0;
        #2;
        check_out("t6c.async", 1'b0, 1'b0);
        check("t6c.div_cur", 32'(div_cur), 4);
        check("t6c.ready", 32'(div_ready), 1);
        step(1);
        rst_n = 1'b1;
        step(3);
        check_out("t6c.pre_rise", 1'b0, 1'b0);
        step(1);
        check_out("t6c.rise", 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
Parametrised, runtime-programmable clock divider and tick generator that generalises the fixed 40 MHz → 50 Hz divider.
- Outputs a 50 % toggle clock (clk_out) and a one-cycle strobe (tick) at every terminal count.
- The divisor is loaded at runtime through a valid/ready handshake and is applied only on a period boundary, so the output never shows a glitch.
- Sits next to the slow-rate consumers (servo/PWM timing, display refresh, debouncers) and is instantiated once per required rate.

Parameters:
- CTR_WIDTH, 19, width of the counter and divisor; maximum divisor is 2^CTR_WIDTH-1.
- DEFAULT_DIV, 400_000, divisor loaded at reset; with a 40 MHz clk this gives clk_out = 50 Hz.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low the counter and clk_out freeze.
- clr  in  1  synchronous phase clear.
- div_in  in  CTR_WIDTH  requested half-period divisor, in clk cycles.
- div_valid  in  1  div_in is valid.
- div_ready  out  1  block can accept a new divisor.
- clk_out  out  1  divided clock; period = 2*div_cur clk cycles.
- tick  out  1  one-cycle strobe at each toggle of clk_out.
- div_cur  out  CTR_WIDTH  divisor currently in effect.

Behaviour:
Reset (rst_n=0, asynchronous):
- ctr=0, clk_out=0, tick=0.
- div_cur=DEFAULT_DIV, pending register empty, div_ready=1.
- Deasserting reset mid-period restarts cleanly from ctr=0.

Counting:
- Terminal count is ctr == div_cur-1, evaluated while en=1.
- On terminal: ctr←0, clk_out←~clk_out, tick←1 for exactly one cycle.
- Otherwise ctr←ctr+1, tick←0.
- All outputs are registered. tick and the clk_out toggle appear on the same clock edge.
- Latency: from reset release or clr, the first toggle occurs on the div_cur-th enabled edge.

Enable:
- en=0: ctr and clk_out hold their values, tick=0.
- Counting resumes from the held ctr when en returns to 1; no phase loss.

Divisor handshake:
- A transfer occurs when div_valid && div_ready on a clock edge. div_in is then captured into the pending register and div_ready←0.
- div_valid while div_ready=0 is ignored; it is neither stalled nor queued.
- The pending value is applied on the first terminal count strictly after the accept edge, or immediately on the next edge if en=0 or clr=1.
- On apply: div_cur←pending, ctr←0, div_ready←1.
- If accept and terminal occur on the same edge, the old divisor is used for that terminal; the new divisor applies at the following terminal.
- div_in=0 is clamped to 1 on capture.
- With div_cur=1, clk_out toggles every cycle (clk/2) and tick stays high continuously while en=1.

Clear:
- clr=1 on an edge: ctr←0, clk_out←0, tick←0, and any pending divisor is applied.
- clr has priority over terminal and over en; no tick is produced in a clr cycle.
- An accept in the same cycle as clr is captured and remains pending.

Width rules:
- ctr and div_cur are unsigned CTR_WIDTH bits.
- The comparison uses div_cur-1 computed in CTR_WIDTH bits; the clamp guarantees no underflow.

Test Plan:
1. DEFAULT_DIV=4, CTR_WIDTH=8, en=1 after reset → clk_out period 8 cycles; first rise on the 4th edge after reset release; tick high 1 cycle at every edge of clk_out; div_cur=4.
2. Default parameters (400_000, 19) → clk_out high for 400_000 clk cycles, then low for 400_000; tick count = 2 per 800_000 cycles.
3. DEFAULT_DIV=4; send div_in=2 at ctr=1 → div_ready drops next cycle; current half-period still 4 cycles; subsequent half-periods 2 cycles; div_ready=1 and div_cur=2 at the apply edge; a second div_valid while busy is ignored.
4. div_in=0 accepted → div_cur=1; clk_out toggles every cycle; tick held at 1.
5. en low for 10 cycles at ctr=2 → clk_out and ctr frozen, tick=0; the toggle occurs 2 enabled cycles after en returns (div=4).
6. clr asserted coincident with terminal count, and rst_n pulsed low asynchronously mid-period → clr case: no tick, clk_out=0, ctr=0; reset case: all outputs return immediately to reset values with div_cur=DEFAULT_DIV.
